hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Producer of the `stall` and `kill` signals that the main/ALU control and PC control consume.
- Tracks the destination register, register-write and memory-read flags of instructions in the EX, MEM and WB stages in a three-stage shadow pipeline.
- Each cycle, compares these against the ID-stage source operands to generate load-use stalls, the branch kill and the operand forwarding selects.
- Sits beside the ID stage; its outputs drive the control units, the IF/ID register enable and the operand muxes.

Parameters:
- REG_BITS, 3, width of a register specifier (8 architectural registers).
- CNT_BITS, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_src1  input  REG_BITS  first source register.
- id_src2  input  REG_BITS  second source register.
- id_use1  input  1  instruction reads src1.
- id_use2  input  1  instruction reads src2.
- id_dest  input  REG_BITS  destination register.
- id_reg_wr  input  1  instruction writes the register file.
- id_mem_rd  input  1  instruction is a load.
- id_branch_taken  input  1  branch/jump resolved taken in ID.
- stall  output  1  hold PC and IF/ID; insert a bubble into EX.
- kill  output  1  flush IF/ID (squash the fetched instruction).
- fwd_a  output  2  src1 select: 0=regfile, 1=EX ALU result, 2=MEM stage data, 3=WB data.
- fwd_b  output  2  src2 select, same encoding as fwd_a.
- stall_count  output  CNT_BITS  number of stall cycles since reset, saturating.

Behaviour:
- State: three stage records (EX, MEM, WB), each holding {valid, dest, reg_wr, mem_rd}, plus stall_count.
- Reset (async):
  - all stage valids = 0, stall_count = 0.
  - While reset is high, stall, kill, fwd_a and fwd_b are forced to 0.
- Per-stage hazard relevance: a stage record can cause a hazard only if valid=1, reg_wr=1 and dest != 0. R0 is hardwired zero and is never a hazard or a forwarding source.
- Match definition: operand k matches a stage when id_valid=1, id_usek=1, the stage record is hazard-relevant, and id_srck = dest.
- stall (combinational):
  - stall = 1 if EX.mem_rd=1 and EX matches src1 or src2.
  - This is the load-use hazard: exactly one stall cycle per hazard, since the load moves to MEM on the next edge.
- Forwarding (combinational), per operand, priority EX > MEM > WB:
  - EX match and EX.mem_rd=0 -> 1.
  - else MEM match -> 2. This covers a load in MEM supplying memory data.
  - else WB match -> 3.
  - else 0.
  - An EX-stage load match yields fwd=0 while stall=1; the value is don't-care and is recomputed the following cycle.
- kill (combinational):
  - kill = id_branch_taken & id_valid & ~stall.
  - A taken branch that is stalled produces no kill until the stall cycle ends.
- Sequential advance, every rising clk edge out of reset:
  - WB <= MEM; MEM <= EX.
  - EX <= {id_valid & ~stall, id_dest, id_reg_wr, id_mem_rd}. A stall inserts a bubble with valid=0.
  - stall_count increments when stall=1, saturating at all-ones (no wrap).
- Simultaneous events:
  - stall and branch_taken together -> stall wins, kill=0.
  - Operand matches in both EX and WB -> EX wins.
  - src1 = src2 -> both selects are identical.
- Reset mid-operation: all in-flight records are discarded. No stall or forward is produced until new instructions enter.

Decomposition:
- Shared package (`pipeline_pkg`) holds:
  - FWD_REGFILE=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3.
  - The stage-record struct type {valid, dest, reg_wr, mem_rd}.
  - ZERO_REG=0.
- One natural sub-module: `hazard_match`, a combinational block that takes one operand (src, use) and the three stage records and returns {match_ex, match_mem, match_wb}. It is instantiated twice, once per operand.

Test Plan:
- Reset mid-stream with an EX load of R3 and ID using R3 -> stall=0, fwd_a=0 during reset; stall_count=0 after release.
- ADD R3 then SUB using src1=R3 in the next cycle -> fwd_a=1, stall=0. Two cycles later, a user of R3 -> fwd_a=3.
- LOAD R2 then ADD using src2=R2 -> exactly one cycle of stall=1 with a bubble into EX. The next cycle gives stall=0, fwd_b=2; stall_count=1.
- Write R0 in EX, ID reads R0 -> fwd_a=0, stall=0. EX writes R4 and WB writes R4, ID reads R4 on both operands -> fwd_a=fwd_b=1.
- Taken branch in ID with no hazard -> kill=1 for one cycle. Taken branch behind a load-use on R5 -> cycle 1: stall=1, kill=0; cycle 2: stall=0, kill=1.
- With CNT_BITS=2, apply 5 load-use stalls -> stall_count saturates at 3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the hazard/forwarding logic: forwarding select codes,
// the per-stage shadow record, and the hazard-relevance and select helpers.
package pipeline_pkg;

  localparam int unsigned MAX_REG_BITS = 8;
  localparam logic [MAX_REG_BITS-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EX      = 2'd1,
    FWD_MEM     = 2'd2,
    FWD_WB      = 2'd3
  } fwd_sel_t;

  // dest is sized for the widest supported register file and zero-extended
  // by the top, so one struct type serves every REG_BITS setting.
  typedef struct packed {
    logic                    valid;
    logic [MAX_REG_BITS-1:0] dest;
    logic                    reg_wr;
    logic                    mem_rd;
  } stage_t;

  function automatic logic relevant(input stage_t s);
    return s.valid & s.reg_wr & (s.dest != ZERO_REG);
  endfunction

  function automatic fwd_sel_t fwd_select(input logic hit_ex, input logic hit_mem,
                                          input logic hit_wb, input logic ex_load);
    fwd_sel_t sel;
    sel = FWD_REGFILE;
    if (hit_ex && !ex_load) sel = FWD_EX;
    else if (hit_mem)       sel = FWD_MEM;
    else if (hit_wb)        sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID-stage source operand against the EX, MEM and WB records.
module hazard_match
  import pipeline_pkg::*;
(
  input  logic                    valid,
  input  logic                    used,
  input  logic [MAX_REG_BITS-1:0] src,
  input  stage_t                  ex_stage,
  input  stage_t                  mem_stage,
  input  stage_t                  wb_stage,
  output logic                    match_ex,
  output logic                    match_mem,
  output logic                    match_wb
);

  logic reads;

  assign reads     = valid & used;
  assign match_ex  = reads & relevant(ex_stage)  & (src == ex_stage.dest);
  assign match_mem = reads & relevant(mem_stage) & (src == mem_stage.dest);
  assign match_wb  = reads & relevant(wb_stage)  & (src == wb_stage.dest);

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall, branch kill and operand forwarding selects, driven by a
// three-stage shadow of the EX/MEM/WB destination records.
module hazard_forward_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_BITS = 3,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_src1,
  input  logic [REG_BITS-1:0] id_src2,
  input  logic                id_use1,
  input  logic                id_use2,
  input  logic [REG_BITS-1:0] id_dest,
  input  logic                id_reg_wr,
  input  logic                id_mem_rd,
  input  logic                id_branch_taken,
  output logic                stall,
  output logic                kill,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [CNT_BITS-1:0] stall_count
);

  stage_t ex_q, mem_q, wb_q;
  logic   a_ex, a_mem, a_wb;
  logic   b_ex, b_mem, b_wb;
  logic   load_use;

  hazard_match u_match_a (
    .valid     (id_valid),
    .used      (id_use1),
    .src       (MAX_REG_BITS'(id_src1)),
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .wb_stage  (wb_q),
    .match_ex  (a_ex),
    .match_mem (a_mem),
    .match_wb  (a_wb)
  );

  hazard_match u_match_b (
    .valid     (id_valid),
    .used      (id_use2),
    .src       (MAX_REG_BITS'(id_src2)),
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .wb_stage  (wb_q),
    .match_ex  (b_ex),
    .match_mem (b_mem),
    .match_wb  (b_wb)
  );

  assign load_use = ex_q.mem_rd & (a_ex | b_ex);

  always_comb begin
    stall = 1'b0;
    kill  = 1'b0;
    fwd_a = FWD_REGFILE;
    fwd_b = FWD_REGFILE;
    if (!reset) begin
      stall = load_use;
      kill  = id_branch_taken & id_valid & ~load_use;
      fwd_a = fwd_select(a_ex, a_mem, a_wb, ex_q.mem_rd);
      fwd_b = fwd_select(b_ex, b_mem, b_wb, ex_q.mem_rd);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      wb_q         <= mem_q;
      mem_q        <= ex_q;
      ex_q.valid   <= id_valid & ~load_use;
      ex_q.dest    <= MAX_REG_BITS'(id_dest);
      ex_q.reg_wr  <= id_reg_wr;
      ex_q.mem_rd  <= id_mem_rd;
      if (load_use && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: expected outputs are queued when a
// step is driven and checked on the following falling edge.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use1, id_use2, id_reg_wr, id_mem_rd, id_branch_taken;
  logic [2:0]  id_src1, id_src2, id_dest;
  logic        stall, kill, stall2, kill2;
  logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  typedef struct {
    string       tag;
    logic        stall;
    logic        kill;
    logic [1:0]  fa;
    logic [1:0]  fb;
    bit          chk_fwd;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_cnt = '0;
  logic [1:0]  model_cnt2 = '0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .id_branch_taken(id_branch_taken), .stall(stall), .kill(kill),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  hazard_forward_unit #(.REG_BITS(3), .CNT_BITS(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .id_branch_taken(id_branch_taken), .stall(stall2), .kill(kill2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_count(stall_count2)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input string field, input logic [15:0] got,
                     input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s.%s got %0h expected %0h", tag, field, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic es, input logic ek,
                          input logic [1:0] ea, input logic [1:0] eb, input bit chk_fwd);
    exp_t e;
    e.tag = tag; e.stall = es; e.kill = ek; e.fa = ea; e.fb = eb;
    e.chk_fwd = chk_fwd; e.cnt = model_cnt; e.cnt2 = model_cnt2;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL scoreboard got empty queue expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.tag, "stall", 16'(stall), 16'(e.stall));
      chk(e.tag, "kill", 16'(kill), 16'(e.kill));
      if (e.chk_fwd) begin
        chk(e.tag, "fwd_a", 16'(fwd_a), 16'(e.fa));
        chk(e.tag, "fwd_b", 16'(fwd_b), 16'(e.fb));
      end
      chk(e.tag, "stall_count", stall_count, e.cnt);
      chk(e.tag, "stall_count_sat", 16'(stall_count2), 16'(e.cnt2));
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                       input logic u1, input logic u2, input logic [2:0] d,
                       input logic wr, input logic rd, input logic br);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_use1 = u1; id_use2 = u2;
    id_dest = d; id_reg_wr = wr; id_mem_rd = rd; id_branch_taken = br;
  endtask

  // One ID-stage cycle: drive, expect, check on the falling edge, advance.
  task automatic step(input string tag, input logic v, input logic [2:0] s1,
                      input logic [2:0] s2, input logic u1, input logic u2,
                      input logic [2:0] d, input logic wr, input logic rd, input logic br,
                      input logic es, input logic ek, input logic [1:0] ea,
                      input logic [1:0] eb, input bit chk_fwd);
    drive(v, s1, s2, u1, u2, d, wr, rd, br);
    push_exp(tag, es, ek, ea, eb, chk_fwd);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    if (es) begin
      if (model_cnt != 16'hFFFF) model_cnt++;
      if (model_cnt2 != 2'd3) model_cnt2++;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //   tag            v s1 s2 u1 u2 d wr rd br  stall kill fa fb chk
    step("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    step("ld_r3",       1, 0, 0, 0, 0, 3, 1, 1, 0,  0, 0, 0, 0, 1);
    step("lu_r3_stall", 1, 3, 0, 1, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0);
    step("lu_r3_fwd",   1, 3, 0, 1, 0, 1, 1, 0, 0,  0, 0, 2, 0, 1);
    step("ld_r3_again", 1, 0, 0, 0, 0, 3, 1, 1, 0,  0, 0, 0, 0, 1);

    // Reset asserted while EX holds a load of R3 and ID reads R3.
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_cnt = '0;
    model_cnt2 = '0;
    push_exp("reset_mid", 0, 0, 0, 0, 1);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1 reset = 1'b0;

    step("post_reset",  1, 3, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    step("add_r3",      1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 1);
    step("sub_fwd_ex",  1, 3, 0, 1, 0, 6, 1, 0, 0,  0, 0, 1, 0, 1);
    step("nop",         1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    step("fwd_wb_mem",  1, 3, 6, 1, 1, 0, 0, 0, 0,  0, 0, 3, 2, 1);
    step("ld_r2",       1, 0, 0, 0, 0, 2, 1, 1, 0,  0, 0, 0, 0, 1);
    step("lu_r2_stall", 1, 0, 2, 0, 1, 7, 1, 0, 0,  1, 0, 0, 0, 0);
    step("lu_r2_fwd",   1, 0, 2, 0, 1, 7, 1, 0, 0,  0, 0, 0, 2, 1);
    step("wr_r0",       1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1);
    step("rd_r0",       1, 0, 0, 1, 1, 4, 1, 0, 0,  0, 0, 0, 0, 1);
    step("wr_r5",       1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 1);
    step("wr_r4",       1, 0, 0, 0, 0, 4, 1, 0, 0,  0, 0, 0, 0, 1);
    step("r4_ex_over_wb", 1, 4, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step("br_kill",     1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1);
    step("br_invalid",  0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1);
    step("ld_r5",       1, 0, 0, 0, 0, 5, 1, 1, 0,  0, 0, 0, 0, 1);
    step("br_stalled",  1, 5, 0, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0);
    step("br_released", 1, 5, 0, 1, 0, 0, 0, 0, 1,  0, 1, 2, 0, 1);
    step("bubble",      0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

    // Three more load-use stalls push the 2-bit counter past its ceiling.
    for (int i = 0; i < 3; i++) begin
      step("sat_ld",    1, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 1);
      step("sat_stall", 1, 1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      step("sat_fwd",   1, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2, 0, 1);
    end
    step("final",       0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
